// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/halt controller.
package hazard_pkg;

  localparam int unsigned HZ_CNT_W = 32;
  localparam int unsigned HZ_REG_W = 5;

  typedef enum logic [0:0] {
    HZ_RUN  = 1'b0,
    HZ_HALT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/EX hazard inputs and stall/flush/halt/counter outputs.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = HZ_CNT_W
);
  logic                MemRead_id_ex;
  logic [HZ_REG_W-1:0] regfile_write_num_id_ex;
  logic [HZ_REG_W-1:0] regfile_read_num1_syscall_id;
  logic [HZ_REG_W-1:0] regfile_read_num2_syscall_id;
  logic                uses_rs_id;
  logic                uses_rt_id;
  logic                branch_taken_ex;
  logic                jump_ex;
  logic                syscall_halt_ex;
  logic                go;

  logic                nop_lock_id;
  logic                pc_bj;
  logic                halt_ex;
  logic                pc_write_en;
  logic                if_id_write_en;
  logic                halted;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output MemRead_id_ex, regfile_write_num_id_ex, regfile_read_num1_syscall_id,
           regfile_read_num2_syscall_id, uses_rs_id, uses_rt_id, branch_taken_ex,
           jump_ex, syscall_halt_ex, go,
    input  nop_lock_id, pc_bj, halt_ex, pc_write_en, if_id_write_en, halted,
           cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  MemRead_id_ex, regfile_write_num_id_ex, regfile_read_num1_syscall_id,
           regfile_read_num2_syscall_id, uses_rs_id, uses_rt_id, branch_taken_ex,
           jump_ex, syscall_halt_ex, go,
    output nop_lock_id, pc_bj, halt_ex, pc_write_en, if_id_write_en, halted,
           cycle_cnt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/perf_counter.sv
// Free-running wrapping event counter with synchronous active-high reset.
module perf_counter #(
  parameter int unsigned CNT_W = hazard_pkg::HZ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/halt control for the 5-stage core: RUN/HALT FSM, hazard
// decode with halt > control-flow > load-use priority, and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = HZ_CNT_W
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  hz_state_t state_q;
  hz_state_t state_d;

  logic lu_c;
  logic cf_c;
  logic run_c;
  logic nop_lock_c;
  logic pc_bj_c;
  logic pc_we_c;
  logic if_id_we_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= HZ_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:  if (hz.syscall_halt_ex) state_d = HZ_HALT;
      HZ_HALT: if (hz.go)              state_d = HZ_RUN;
      default: state_d = HZ_RUN;
    endcase
  end

  // Register 0 is never a real producer, so a load into it cannot stall.
  assign lu_c = hz.MemRead_id_ex && (hz.regfile_write_num_id_ex != '0) &&
                ((hz.uses_rs_id && (hz.regfile_read_num1_syscall_id == hz.regfile_write_num_id_ex)) ||
                 (hz.uses_rt_id && (hz.regfile_read_num2_syscall_id == hz.regfile_write_num_id_ex)));
  assign cf_c  = hz.branch_taken_ex || hz.jump_ex;
  assign run_c = (state_q == HZ_RUN);

  always_comb begin
    nop_lock_c = 1'b0;
    pc_bj_c    = 1'b0;
    pc_we_c    = 1'b0;
    if_id_we_c = 1'b0;
    if (run_c && !hz.syscall_halt_ex) begin
      if (cf_c) begin
        // A squashed ID instruction cannot cause a load-use stall.
        pc_bj_c    = 1'b1;
        pc_we_c    = 1'b1;
        if_id_we_c = 1'b1;
      end else if (lu_c) begin
        nop_lock_c = 1'b1;
      end else begin
        pc_we_c    = 1'b1;
        if_id_we_c = 1'b1;
      end
    end
  end

  assign hz.nop_lock_id    = nop_lock_c;
  assign hz.pc_bj          = pc_bj_c;
  assign hz.pc_write_en    = pc_we_c;
  assign hz.if_id_write_en = if_id_we_c;
  assign hz.halt_ex        = !run_c;
  assign hz.halted         = !run_c;

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (run_c),
    .cnt (hz.cycle_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (nop_lock_c),
    .cnt (hz.stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pc_bj_c),
    .cnt (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, hand sequences, random vs model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hz ();
  hazard_ctrl_if #(.CNT_W(4))  hz4 ();

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .hz  (hz4)
  );

  typedef struct {
    logic       rst, mr;
    logic [4:0] dst, n1, n2;
    logic       urs, urt, br, jp, sys, go;
    logic       e_nop, e_bj, e_pcw, e_ifw, e_h;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  bit          m_halted;
  logic [31:0] m_cyc, m_stl, m_fls;

  vec_t tab[$];

  function automatic vec_t mk(input logic r, mr, input logic [4:0] dst, n1, n2,
                              input logic urs, urt, br, jp, sys, go,
                              input logic e_nop, e_bj, e_pcw, e_ifw, e_h);
    vec_t v;
    v.rst = r; v.mr = mr; v.dst = dst; v.n1 = n1; v.n2 = n2;
    v.urs = urs; v.urt = urt; v.br = br; v.jp = jp; v.sys = sys; v.go = go;
    v.e_nop = e_nop; v.e_bj = e_bj; v.e_pcw = e_pcw; v.e_ifw = e_ifw; v.e_h = e_h;
    return v;
  endfunction

  function automatic vec_t idle(input logic r, input logic sys, input logic go);
    return mk(r, 0, 0, 0, 0, 0, 0, 0, 0, sys, go, 0, 0, 0, 0, 0);
  endfunction

  // Expected {nop_lock_id, pc_bj, pc_write_en, if_id_write_en} from the rules.
  function automatic logic [3:0] model_out(input vec_t v, input bit h);
    bit lu, cf;
    lu = v.mr && (v.dst != 0) && ((v.urs && v.n1 == v.dst) || (v.urt && v.n2 == v.dst));
    cf = v.br || v.jp;
    if (h || v.sys) return 4'b0000;
    if (cf)         return 4'b0111;
    if (lu)         return 4'b1000;
    return 4'b0011;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                             = v.rst;
    hz.MemRead_id_ex                = v.mr;
    hz.regfile_write_num_id_ex      = v.dst;
    hz.regfile_read_num1_syscall_id = v.n1;
    hz.regfile_read_num2_syscall_id = v.n2;
    hz.uses_rs_id                   = v.urs;
    hz.uses_rt_id                   = v.urt;
    hz.branch_taken_ex              = v.br;
    hz.jump_ex                      = v.jp;
    hz.syscall_halt_ex              = v.sys;
    hz.go                           = v.go;
  endtask

  // One cycle: drive at negedge, check just after, then advance the model.
  task automatic step(input vec_t v, input bit use_tab);
    logic [3:0] m;
    logic [3:0] e;
    logic       eh;
    @(negedge clk);
    drive(v);
    #1;
    m  = model_out(v, m_halted);
    e  = use_tab ? {v.e_nop, v.e_bj, v.e_pcw, v.e_ifw} : m;
    eh = use_tab ? v.e_h : m_halted;
    chk("nop_lock_id",    32'(hz.nop_lock_id),    32'(e[3]));
    chk("pc_bj",          32'(hz.pc_bj),          32'(e[2]));
    chk("pc_write_en",    32'(hz.pc_write_en),    32'(e[1]));
    chk("if_id_write_en", 32'(hz.if_id_write_en), 32'(e[0]));
    chk("halted",         32'(hz.halted),         32'(eh));
    chk("halt_ex",        32'(hz.halt_ex),        32'(eh));
    chk("cycle_cnt",      hz.cycle_cnt,           m_cyc);
    chk("stall_cnt",      hz.stall_cnt,           m_stl);
    chk("flush_cnt",      hz.flush_cnt,           m_fls);
    if (v.rst) begin
      m_halted = 1'b0;
      m_cyc = '0; m_stl = '0; m_fls = '0;
    end else if (!m_halted) begin
      m_cyc = m_cyc + 1;
      if (m[3]) m_stl = m_stl + 1;
      if (m[2]) m_fls = m_fls + 1;
      if (v.sys) m_halted = 1'b1;
    end else if (v.go) begin
      m_halted = 1'b0;
    end
  endtask

  initial begin
    vec_t v;

    // rst mr dst n1 n2 urs urt br jp sys go | nop bj pcw ifw h
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0));
    tab.push_back(mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0));
    tab.push_back(mk(0, 1, 7, 3, 7, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 7, 7, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0));
    tab.push_back(mk(0, 0, 9, 9, 9, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0));
    tab.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 0, 0,   0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0));
    tab.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 1, 0,   0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 1, 1, 0,   0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0));

    drive(idle(1, 0, 0));
    rst4 = 1'b1;
    hz4.MemRead_id_ex = 0; hz4.regfile_write_num_id_ex = 0;
    hz4.regfile_read_num1_syscall_id = 0; hz4.regfile_read_num2_syscall_id = 0;
    hz4.uses_rs_id = 0; hz4.uses_rt_id = 0; hz4.branch_taken_ex = 0;
    hz4.jump_ex = 0; hz4.syscall_halt_ex = 0; hz4.go = 0;
    repeat (2) @(posedge clk);

    // 4-bit counter wraps after 16 RUN cycles.
    @(negedge clk);
    rst4 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("wrap cycle_cnt at 15", 32'(hz4.cycle_cnt), 32'd15);
    @(posedge clk);
    #1;
    chk("wrap cycle_cnt to 0", 32'(hz4.cycle_cnt), 32'd0);
    chk("wrap stall_cnt", 32'(hz4.stall_cnt), 32'd0);

    m_halted = 1'b0;
    m_cyc = '0; m_stl = '0; m_fls = '0;
    foreach (tab[i]) step(tab[i], 1'b1);

    // Halt, hold ten cycles with counters frozen, then resume.
    step(idle(0, 1, 0), 1'b0);
    for (int i = 0; i < 10; i++) step(idle(0, 0, 0), 1'b0);
    step(idle(0, 0, 1), 1'b0);
    step(idle(0, 0, 0), 1'b0);
    step(idle(0, 0, 0), 1'b0);

    // Reset while halted, with a concurrent go.
    step(idle(0, 1, 0), 1'b0);
    step(idle(0, 0, 0), 1'b0);
    step(idle(1, 0, 1), 1'b0);
    step(idle(0, 0, 0), 1'b0);
    step(idle(0, 0, 0), 1'b0);

    for (int i = 0; i < 400; i++) begin
      v = idle(0, 0, 0);
      v.rst = ($urandom_range(0, 63) == 0);
      v.mr  = $urandom_range(0, 1);
      v.dst = 5'($urandom_range(0, 3));
      v.n1  = 5'($urandom_range(0, 3));
      v.n2  = 5'($urandom_range(0, 3));
      v.urs = $urandom_range(0, 1);
      v.urt = $urandom_range(0, 1);
      v.br  = ($urandom_range(0, 5) == 0);
      v.jp  = ($urandom_range(0, 7) == 0);
      v.sys = ($urandom_range(0, 15) == 0);
      v.go  = ($urandom_range(0, 3) == 0);
      step(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
